// File: rtl/alu_scheduler.sv
// alu_scheduler
// Shares one combinational ALU between two requesters. A winning request is
// registered into a single issue stage that drives the ALU for one cycle; the
// ALU result is then captured into that requester's response register, which
// is held until the requester acknowledges it. Grant-to-response latency is
// two cycles, and throughput is one operation per cycle across both ports.
//
// Build option: define ALU_SCHED_RR_EN for a round-robin tie-break. When it is
// left undefined, requester 0 wins every tie and no round-robin state exists.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   reqN, opN, aN, bN, shamtN     requester N operation (held until gntN)
//   gntN                          combinational grant, operation accepted this cycle
//   alu_op, alu_a, alu_b,
//   alu_shamt                     drive to the shared ALU (all zero while idle)
//   alu_result, alu_zero          return from the shared ALU
//   rspN_valid/result/zero/err    held response for requester N
//   rspN_ack                      requester N consumes its response
module alu_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [4:0]  shamt0,
  input  logic [4:0]  shamt1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output logic        rsp0_zero,
  output logic        rsp1_zero,
  output logic        rsp0_err,
  output logic        rsp1_err,
  input  logic        rsp0_ack,
  input  logic        rsp1_ack
);

  // Per-requester views of the flat ports, indexed by requester id.
  logic [1:0]       req_vec;
  logic [1:0]       ack_vec;
  logic [1:0][3:0]  op_vec;
  logic [1:0][31:0] a_vec;
  logic [1:0][31:0] b_vec;
  logic [1:0][4:0]  shamt_vec;

  assign req_vec   = {req1, req0};
  assign ack_vec   = {rsp1_ack, rsp0_ack};
  assign op_vec    = {op1, op0};
  assign a_vec     = {a1, a0};
  assign b_vec     = {b1, b0};
  assign shamt_vec = {shamt1, shamt0};

  // Issue stage
  logic        issue_valid_reg;
  logic        issue_id_reg;
  logic [3:0]  issue_op_reg;
  logic [31:0] issue_a_reg;
  logic [31:0] issue_b_reg;
  logic [4:0]  issue_shamt_reg;

  // Arbitration
  logic [1:0] eligible;
  logic [1:0] cand;
  logic [1:0] gnt_vec;
  logic       gnt_id;

  // Collected response state
  logic [1:0]       rsp_valid;
  logic [1:0][31:0] rsp_result;
  logic [1:0]       rsp_zero;
  logic [1:0]       rsp_err;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic        own_issue;
      logic        valid_reg;
      logic [31:0] result_reg;
      logic        zero_reg;
      logic        err_reg;

      assign own_issue = issue_valid_reg && (issue_id_reg == 1'(gi));

      // An ack in the same cycle frees the response slot, so a requester can
      // be re-granted while its old response is still visible: the old one
      // clears on the next edge and the new one lands an edge later.
      assign eligible[gi] = !own_issue && (!valid_reg || ack_vec[gi]);
      assign cand[gi]     = req_vec[gi] && eligible[gi];

      // Completion takes priority over ack; the eligibility rule keeps the two
      // from ever coinciding for the same requester.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg  <= 1'b0;
          result_reg <= 32'd0;
          zero_reg   <= 1'b0;
          err_reg    <= 1'b0;
        end else if (own_issue) begin
          valid_reg  <= 1'b1;
          result_reg <= alu_result;
          zero_reg   <= alu_zero;
          err_reg    <= issue_op_reg[3];
        end else if (ack_vec[gi]) begin
          valid_reg  <= 1'b0;
        end
      end

      assign rsp_valid[gi]  = valid_reg;
      assign rsp_result[gi] = result_reg;
      assign rsp_zero[gi]   = zero_reg;
      assign rsp_err[gi]    = err_reg;
    end
  endgenerate

`ifdef ALU_SCHED_RR_EN
  // Id of the most recent grant; starts at 1 so requester 0 wins the first tie.
  logic last_gnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_reg <= 1'b1;
    end else if (|gnt_vec) begin
      last_gnt_reg <= gnt_vec[1];
    end
  end
`endif

  // Grants are suppressed while reset is asserted so every output reads zero.
  always_comb begin
    gnt_vec = 2'b00;
    if (!reset) begin
`ifdef ALU_SCHED_RR_EN
      if (cand == 2'b11) begin
        gnt_vec = last_gnt_reg ? 2'b01 : 2'b10;
      end else begin
        gnt_vec = cand;
      end
`else
      if (cand[0]) begin
        gnt_vec = 2'b01;
      end else if (cand[1]) begin
        gnt_vec = 2'b10;
      end
`endif
    end
  end

  assign gnt_id = gnt_vec[1];
  assign gnt0   = gnt_vec[0];
  assign gnt1   = gnt_vec[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid_reg <= 1'b0;
      issue_id_reg    <= 1'b0;
      issue_op_reg    <= 4'd0;
      issue_a_reg     <= 32'd0;
      issue_b_reg     <= 32'd0;
      issue_shamt_reg <= 5'd0;
    end else begin
      issue_valid_reg <= |gnt_vec;
      if (|gnt_vec) begin
        issue_id_reg    <= gnt_id;
        issue_op_reg    <= op_vec[gnt_id];
        issue_a_reg     <= a_vec[gnt_id];
        issue_b_reg     <= b_vec[gnt_id];
        issue_shamt_reg <= shamt_vec[gnt_id];
      end
    end
  end

  // Stale operands stay in the issue registers when idle; mask them off.
  assign alu_op    = issue_valid_reg ? issue_op_reg    : 4'd0;
  assign alu_a     = issue_valid_reg ? issue_a_reg     : 32'd0;
  assign alu_b     = issue_valid_reg ? issue_b_reg     : 32'd0;
  assign alu_shamt = issue_valid_reg ? issue_shamt_reg : 5'd0;

  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_zero   = rsp_zero[0];
  assign rsp1_zero   = rsp_zero[1];
  assign rsp0_err    = rsp_err[0];
  assign rsp1_err    = rsp_err[1];

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: directed scenarios plus a randomized run checked
// against a transaction-level reference model (queue of in-flight operations).
// The bench also models the shared combinational ALU driving alu_result/alu_zero.
module tb_alu_scheduler;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic [4:0]  shamt0, shamt1;
  logic        gnt0, gnt1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic        rsp0_ack, rsp1_ack;

  int n_cmp = 0;
  int n_fail = 0;

  alu_scheduler dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .shamt0(shamt0), .shamt1(shamt1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .rsp0_ack(rsp0_ack), .rsp1_ack(rsp1_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return ~(a | b);
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return b << sh;
      4'd6: return b >> sh;
      4'd7: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU
  always_comb begin
    alu_result = alu_ref(alu_op, alu_a, alu_b, alu_shamt);
    alu_zero   = (alu_result == 32'd0);
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;   // cycle in which the response becomes visible
    bit          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } flight_t;

  flight_t     flight[$];
  int          cyc = 0;
  bit          m_valid[2];
  logic [31:0] m_result[2];
  bit          m_zero[2];
  bit          m_err[2];
`ifdef ALU_SCHED_RR_EN
  bit          m_last = 1'b1;
`endif

  function automatic logic [1:0] model_gnt();
    logic [1:0] busy;
    logic [1:0] cand;
    busy = 2'b00;
    foreach (flight[i]) busy[flight[i].id] = 1'b1;
    cand[0] = req0 && !busy[0] && (!m_valid[0] || rsp0_ack);
    cand[1] = req1 && !busy[1] && (!m_valid[1] || rsp1_ack);
    if (reset) return 2'b00;
    if (cand == 2'b11) begin
`ifdef ALU_SCHED_RR_EN
      return m_last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return cand;
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    flight_t    f;
    g = model_gnt();
    if (reset) begin
      flight.delete();
      for (int n = 0; n < 2; n++) begin
        m_valid[n] = 1'b0; m_result[n] = 32'd0; m_zero[n] = 1'b0; m_err[n] = 1'b0;
      end
`ifdef ALU_SCHED_RR_EN
      m_last = 1'b1;
`endif
    end else begin
      if (rsp0_ack) m_valid[0] = 1'b0;
      if (rsp1_ack) m_valid[1] = 1'b0;
      for (int i = flight.size() - 1; i >= 0; i--) begin
        if (flight[i].due == cyc + 1) begin
          m_valid[flight[i].id]  = 1'b1;
          m_result[flight[i].id] = alu_ref(flight[i].op, flight[i].a, flight[i].b, flight[i].sh);
          m_zero[flight[i].id]   = (m_result[flight[i].id] == 32'd0);
          m_err[flight[i].id]    = flight[i].op[3];
          flight.delete(i);
        end
      end
      if (g != 2'b00) begin
        f.due = cyc + 2;
        f.id  = g[1];
        f.op  = g[1] ? op1 : op0;
        f.a   = g[1] ? a1 : a0;
        f.b   = g[1] ? b1 : b0;
        f.sh  = g[1] ? shamt1 : shamt0;
        flight.push_back(f);
`ifdef ALU_SCHED_RR_EN
        m_last = g[1];
`endif
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    req0 = 0; req1 = 0; rsp0_ack = 0; rsp1_ack = 0;
    op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; shamt0 = 0; shamt1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 4'(8 + $urandom_range(0, 7));
    return 4'($urandom_range(0, 7));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1; req0 = 1; req1 = 1; op0 = 3; a0 = 5; b0 = 7; op1 = 1; a1 = 2; b1 = 3;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({gnt0, gnt1, alu_op, alu_a, alu_b, alu_shamt, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
         rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b%b alu_op=%h rsp_valid=%b%b got nonzero, required all zero",
               gnt0, gnt1, alu_op, rsp0_valid, rsp1_valid);
    end
    $display("txn reset: outputs checked while reset held");
    idle();
  endtask

  task automatic test_add();
    do_reset();
    @(negedge clk); req0 = 1; op0 = 3; a0 = 5; b0 = 7; #1;
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL add_gnt: got %b required 10", {gnt0, gnt1});
    end
    @(negedge clk); req0 = 0; #1;
    n_cmp++;
    if ({alu_op, alu_a, alu_b, rsp0_valid} !== {4'd3, 32'd5, 32'd7, 1'b0}) begin
      n_fail++; $display("FAIL add_alu: op=%0d a=%0d b=%0d rsp0_valid=%b required 3 5 7 0",
                         alu_op, alu_a, alu_b, rsp0_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_rsp: valid=%b result=%0d zero=%b err=%b required 1 12 0 0",
                         rsp0_valid, rsp0_result, rsp0_zero, rsp0_err);
    end
    rsp0_ack = 1;
    @(negedge clk); rsp0_ack = 0; #1;
    n_cmp++;
    if ({rsp0_valid, rsp0_result} !== {1'b0, 32'd12}) begin
      n_fail++; $display("FAIL add_ack: valid=%b result=%0d required 0 12", rsp0_valid, rsp0_result);
    end
    $display("txn add: req0 5+7");
  endtask

  task automatic test_sub_zero();
    do_reset();
    @(negedge clk); req1 = 1; op1 = 4; a1 = 9; b1 = 9; #1;
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL sub_gnt: got %b required 01", {gnt0, gnt1});
    end
    @(negedge clk); req1 = 0;
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_rsp: valid=%b result=%0d zero=%b err=%b required 1 0 1 0",
                         rsp1_valid, rsp1_result, rsp1_zero, rsp1_err);
    end
    rsp1_ack = 1;
    @(negedge clk); rsp1_ack = 0;
    $display("txn sub: req1 9-9");
  endtask

  task automatic test_tie();
    logic [1:0] want;
    do_reset();
    @(negedge clk);
    req0 = 1; op0 = 5; b0 = 1; shamt0 = 4; req1 = 1; op1 = 5; b1 = 1; shamt1 = 4; #1;
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL tie_first: got %b required 10", {gnt0, gnt1});
    end
    @(negedge clk); req0 = 0; #1;
    n_cmp++;
    if ({gnt0, gnt1, alu_op, alu_b, alu_shamt} !== {2'b01, 4'd5, 32'd1, 5'd4}) begin
      n_fail++; $display("FAIL tie_second: gnt=%b alu_op=%0d b=%0d shamt=%0d required 01 5 1 4",
                         {gnt0, gnt1}, alu_op, alu_b, alu_shamt);
    end
    @(negedge clk); req1 = 0; #1;
    n_cmp++;
    if ({rsp0_valid, rsp0_result, rsp1_valid} !== {1'b1, 32'd16, 1'b0}) begin
      n_fail++; $display("FAIL tie_rsp0: valid0=%b result0=%0d valid1=%b required 1 16 0",
                         rsp0_valid, rsp0_result, rsp1_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp1_valid, rsp1_result, rsp1_zero} !== {1'b1, 32'd16, 1'b0}) begin
      n_fail++; $display("FAIL tie_rsp1: valid=%b result=%0d zero=%b required 1 16 0",
                         rsp1_valid, rsp1_result, rsp1_zero);
    end
    rsp0_ack = 1; rsp1_ack = 1;
    // Lone grant to requester 0, then a tie while it acks its response.
    @(negedge clk); rsp0_ack = 0; rsp1_ack = 0; req0 = 1; op0 = 3; a0 = 1; b0 = 1; #1;
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL tie_lone: got %b required 10", {gnt0, gnt1});
    end
    @(negedge clk); req0 = 0;
    @(negedge clk);
    rsp0_ack = 1; req0 = 1; op0 = 3; a0 = 2; b0 = 2; req1 = 1; op1 = 3; a1 = 3; b1 = 3; #1;
`ifdef ALU_SCHED_RR_EN
    want = 2'b01;
`else
    want = 2'b10;
`endif
    n_cmp++;
    if ({gnt0, gnt1} !== want) begin
      n_fail++; $display("FAIL tie_after_ack: got %b required %b", {gnt0, gnt1}, want);
    end
    @(negedge clk); idle();
    $display("txn tie: SLL pair then tie after lone grant");
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk); req0 = 1; op0 = 3; a0 = 1; b0 = 2; #1;
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_gnt: got %b required 1", gnt0);
    end
    @(negedge clk); a0 = 10; b0 = 20; #1;
    n_cmp++;
    if (gnt0 !== 1'b0) begin
      n_fail++; $display("FAIL bp_issue_busy: gnt0=%b required 0", gnt0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({gnt0, rsp0_valid, rsp0_result} !== {1'b0, 1'b1, 32'd3}) begin
        n_fail++; $display("FAIL bp_hold: gnt0=%b valid=%b result=%0d required 0 1 3",
                           gnt0, rsp0_valid, rsp0_result);
      end
    end
    @(negedge clk); rsp0_ack = 1; #1;
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL bp_ack_gnt: gnt0=%b required 1", gnt0);
    end
    @(negedge clk); rsp0_ack = 0; req0 = 0; #1;
    n_cmp++;
    if (rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_cleared: valid=%b required 0", rsp0_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd30}) begin
      n_fail++; $display("FAIL bp_second: valid=%b result=%0d required 1 30", rsp0_valid, rsp0_result);
    end
    $display("txn backpressure: second op granted on ack");
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk); req0 = 1; op0 = 4'b1010; a0 = 32'h0000_ffff; b0 = 3;
    @(negedge clk); req0 = 0; #1;
    n_cmp++;
    if (alu_op !== 4'hA) begin
      n_fail++; $display("FAIL ill_alu_op: got %h required a", alu_op);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ill_rsp: valid=%b result=%0d zero=%b err=%b required 1 0 1 1",
                         rsp0_valid, rsp0_result, rsp0_zero, rsp0_err);
    end
    rsp0_ack = 1;
    @(negedge clk); rsp0_ack = 0;
    $display("txn illegal: op 1010");
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); req0 = 1; op0 = 3; a0 = 2; b0 = 2; #1;
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rmid_gnt: got %b required 1", gnt0);
    end
    @(negedge clk); req0 = 0; req1 = 1; op1 = 3; reset = 1; #1;
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_gnt_in_reset: got %b required 00", {gnt0, gnt1});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt0, gnt1, alu_op, alu_a, alu_b, alu_shamt, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
         rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs: rsp0_valid=%b alu_op=%h alu_a=%0d required all zero",
                         rsp0_valid, alu_op, alu_a);
    end
    @(negedge clk); reset = 0; req1 = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (rsp0_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_no_rsp: valid=%b required 0", rsp0_valid);
      end
    end
    $display("txn reset_mid: in-flight op discarded");
  endtask

  task automatic test_random();
    logic [1:0]  eg;
    logic [1:0]  prev_g;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_sh;
    do_reset();
    prev_g = 2'b00;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!(req0 && !prev_g[0])) begin
        req0 = ($urandom_range(0, 3) != 0); op0 = rand_op(); a0 = $urandom;
        b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom; shamt0 = 5'($urandom);
      end
      if (!(req1 && !prev_g[1])) begin
        req1 = ($urandom_range(0, 3) != 0); op1 = rand_op(); a1 = $urandom;
        b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom; shamt1 = 5'($urandom);
      end
      rsp0_ack = 1'($urandom); rsp1_ack = 1'($urandom);
      if (c >= 590) begin req0 = 0; req1 = 0; rsp0_ack = 1; rsp1_ack = 1; end
      #1;
      eg = model_gnt();
      e_op = 0; e_a = 0; e_b = 0; e_sh = 0;
      foreach (flight[i]) begin
        if (flight[i].due == cyc + 1) begin
          e_op = flight[i].op; e_a = flight[i].a; e_b = flight[i].b; e_sh = flight[i].sh;
        end
      end
      n_cmp++;
      if ({gnt1, gnt0} !== eg) begin
        n_fail++; $display("FAIL rnd_gnt cycle %0d: got %b required %b", c, {gnt1, gnt0}, eg);
      end
      n_cmp++;
      if ({alu_op, alu_a, alu_b, alu_shamt} !== {e_op, e_a, e_b, e_sh}) begin
        n_fail++; $display("FAIL rnd_alu cycle %0d: got %h/%h/%h/%h required %h/%h/%h/%h",
                           c, alu_op, alu_a, alu_b, alu_shamt, e_op, e_a, e_b, e_sh);
      end
      n_cmp++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !==
          {m_valid[0], m_result[0], m_zero[0], m_err[0]}) begin
        n_fail++; $display("FAIL rnd_rsp0 cycle %0d: got %b %h %b %b required %b %h %b %b", c,
                           rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
                           m_valid[0], m_result[0], m_zero[0], m_err[0]);
      end
      n_cmp++;
      if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !==
          {m_valid[1], m_result[1], m_zero[1], m_err[1]}) begin
        n_fail++; $display("FAIL rnd_rsp1 cycle %0d: got %b %h %b %b required %b %h %b %b", c,
                           rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
                           m_valid[1], m_result[1], m_zero[1], m_err[1]);
      end
      if (eg != 2'b00)
        $display("txn random: cycle %0d grant to req%0d op=%0d", c, eg[1],
                 eg[1] ? op1 : op0);
      prev_g = eg;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_add();
    test_sub_zero();
    test_tie();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
